blackbox_const_axil_slave: RTL and testbench

- AXI4-Lite responder on the other end of the constant-generator master bus.
- Holds the configuration constants the pitch-training datapath consumes: six read/write words, a read-only ID word and a read-only accepted-write counter.
- Sits on the AXI interconnect as a memory-mapped slave.
- Drives its RW words to downstream logic, with a per-word update strobe.

---
 rtl/blackbox_const_axil_slave.sv | 214 +++++++++++++++++++++
 tb/tb_blackbox_const_axil_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blackbox_const_axil_slave.sv
// AXI4-Lite register slave holding the pitch-training configuration constants:
// six RW words, a read-only ID and a read-only accepted-write counter.
module blackbox_const_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter logic [31:0] ID_VALUE           = 32'hB1AC_C057
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [6*C_S_AXI_DATA_WIDTH-1:0]   CFG_OUT,
    output logic [5:0]                        CFG_WR_PULSE
);

    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned NUM_RW = 6;
    localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Registered state
    logic                          r_aw_full, r_w_full;
    logic [IDX_W-1:0]              r_aw_idx;
    logic [DW-1:0]                 r_w_data;
    logic [SW-1:0]                 r_w_strb;
    logic                          r_awready, r_wready, r_bvalid;
    logic [1:0]                    r_bresp;
    logic                          r_arready, r_rvalid;
    logic [1:0]                    r_rresp;
    logic [DW-1:0]                 r_rdata;
    logic [NUM_RW-1:0][DW-1:0]     r_cfg;
    logic [DW-1:0]                 r_wr_count;
    logic [NUM_RW-1:0]             r_wr_pulse;

    // Next-state values
    logic                          w_aw_full_nxt, w_w_full_nxt;
    logic [IDX_W-1:0]              w_aw_idx_nxt;
    logic [DW-1:0]                 w_w_data_nxt;
    logic [SW-1:0]                 w_w_strb_nxt;
    logic                          w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
    logic [1:0]                    w_bresp_nxt;
    logic                          w_arready_nxt, w_rvalid_nxt;
    logic [1:0]                    w_rresp_nxt;
    logic [DW-1:0]                 w_rdata_nxt;
    logic [NUM_RW-1:0][DW-1:0]     w_cfg_nxt;
    logic [DW-1:0]                 w_wr_count_nxt;
    logic [NUM_RW-1:0]             w_wr_pulse_nxt;

    logic                          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                          w_commit, w_wr_ok;
    logic [IDX_W-1:0]              w_wr_idx, w_ar_idx;
    logic [DW-1:0]                 w_wr_data;
    logic [SW-1:0]                 w_wr_strb;
    logic                          w_unused;

    assign w_aw_hs = S_AXI_AWVALID && r_awready;
    assign w_w_hs  = S_AXI_WVALID  && r_wready;
    assign w_b_hs  = r_bvalid && S_AXI_BREADY;
    assign w_ar_hs = S_AXI_ARVALID && r_arready;
    assign w_r_hs  = r_rvalid && S_AXI_RREADY;

    // Held value wins; otherwise use what is arriving on this edge
    assign w_wr_idx  = r_aw_full ? r_aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr_data = r_w_full  ? r_w_data : S_AXI_WDATA;
    assign w_wr_strb = r_w_full  ? r_w_strb : S_AXI_WSTRB;
    assign w_commit  = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs) && !r_bvalid;
    assign w_wr_ok   = (w_wr_idx < IDX_W'(NUM_RW));
    assign w_ar_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        w_aw_full_nxt  = r_aw_full;
        w_w_full_nxt   = r_w_full;
        w_aw_idx_nxt   = r_aw_idx;
        w_w_data_nxt   = r_w_data;
        w_w_strb_nxt   = r_w_strb;
        w_bvalid_nxt   = r_bvalid;
        w_bresp_nxt    = r_bresp;
        w_rvalid_nxt   = r_rvalid;
        w_rresp_nxt    = r_rresp;
        w_rdata_nxt    = r_rdata;
        w_cfg_nxt      = r_cfg;
        w_wr_count_nxt = r_wr_count;
        w_wr_pulse_nxt = '0;

        // Address/data latches stay full until the B handshake
        if (w_b_hs) begin
            w_aw_full_nxt = 1'b0;
            w_w_full_nxt  = 1'b0;
        end else begin
            if (w_aw_hs) begin
                w_aw_full_nxt = 1'b1;
                w_aw_idx_nxt  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                w_w_full_nxt = 1'b1;
                w_w_data_nxt = S_AXI_WDATA;
                w_w_strb_nxt = S_AXI_WSTRB;
            end
        end

        if (w_commit) begin
            w_bvalid_nxt = 1'b1;
            w_bresp_nxt  = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (w_wr_ok) begin
                for (int n = 0; n < NUM_RW; n++) begin
                    if (w_wr_idx == IDX_W'(n)) begin
                        w_wr_pulse_nxt[n] = 1'b1;
                        for (int b = 0; b < SW; b++) begin
                            if (w_wr_strb[b]) w_cfg_nxt[n][8*b +: 8] = w_wr_data[8*b +: 8];
                        end
                    end
                end
                w_wr_count_nxt = r_wr_count + DW'(1);
            end
        end else if (w_b_hs) begin
            w_bvalid_nxt = 1'b0;
        end

        // Read samples current (pre-commit) register contents
        if (w_ar_hs) begin
            w_rvalid_nxt = 1'b1;
            w_rresp_nxt  = RESP_OKAY;
            w_rdata_nxt  = '0;
            if (w_ar_idx == IDX_W'(NUM_RW)) begin
                w_rdata_nxt = ID_VALUE;
            end else if (w_ar_idx == IDX_W'(NUM_RW + 1)) begin
                w_rdata_nxt = r_wr_count;
            end else if (w_ar_idx < IDX_W'(NUM_RW)) begin
                for (int n = 0; n < NUM_RW; n++) begin
                    if (w_ar_idx == IDX_W'(n)) w_rdata_nxt = r_cfg[n];
                end
            end else begin
                w_rresp_nxt = RESP_SLVERR;
            end
        end else if (w_r_hs) begin
            w_rvalid_nxt = 1'b0;
        end

        w_awready_nxt = !w_aw_full_nxt && !w_bvalid_nxt;
        w_wready_nxt  = !w_w_full_nxt  && !w_bvalid_nxt;
        w_arready_nxt = !w_rvalid_nxt;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_aw_full  <= 1'b0;
            r_w_full   <= 1'b0;
            r_aw_idx   <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_cfg      <= '0;
            r_wr_count <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_aw_full  <= w_aw_full_nxt;
            r_w_full   <= w_w_full_nxt;
            r_aw_idx   <= w_aw_idx_nxt;
            r_w_data   <= w_w_data_nxt;
            r_w_strb   <= w_w_strb_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rresp    <= w_rresp_nxt;
            r_rdata    <= w_rdata_nxt;
            r_cfg      <= w_cfg_nxt;
            r_wr_count <= w_wr_count_nxt;
            r_wr_pulse <= w_wr_pulse_nxt;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign CFG_OUT       = r_cfg;
    assign CFG_WR_PULSE  = r_wr_pulse;

endmodule

// File: tb/tb_blackbox_const_axil_slave.sv
// Directed bench for blackbox_const_axil_slave: register map, handshakes,
// byte strobes, error responses, read/write collision and mid-transaction reset.
module tb_blackbox_const_axil_slave;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [191:0] cfg_out;
    logic [5:0]   cfg_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    logic [31:0] d;
    logic [1:0]  r;

    always #5 clk = ~clk;

    blackbox_const_axil_slave dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .CFG_OUT       (cfg_out),
        .CFG_WR_PULSE  (cfg_pulse)
    );

    // Count cycles with any update strobe active
    always @(negedge clk) if (cfg_pulse != 6'd0) pulse_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        while (!arready && cyc < 50) begin @(negedge clk); cyc++; end
        chk("rd_arready_timeout", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        data = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      output logic [1:0] resp);
        int  cyc = 0;
        bit  done = 1'b0;
        logic aw_go, w_go;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        resp = 2'b11;
        while (!done && cyc < 50) begin
            if (bvalid) begin
                resp = bresp;
                done = 1'b1;
            end else begin
                aw_go = awvalid && awready;
                w_go  = wvalid && wready;
                @(negedge clk);
                if (aw_go) awvalid = 1'b0;
                if (w_go)  wvalid  = 1'b0;
                cyc++;
            end
        end
        chk("wr_bvalid_timeout", 32'(done), 32'd1);
        @(negedge clk);
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = 3'b101; arprot = 3'b011;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(awready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_bvalid",  32'(bvalid), 0);
        chk("rst_rvalid",  32'(rvalid), 0);
        chk("rst_cfg",     32'(|cfg_out), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", 32'(awready), 1);
        chk("post_rst_wready",  32'(wready), 1);
        chk("post_rst_arready", 32'(arready), 1);

        // ID and counter
        rd(6'h18, d, r);
        chk("rd_id", d, 32'hB1AC_C057);
        chk("rd_id_resp", 32'(r), 0);
        rd(6'h1C, d, r);
        chk("rd_cnt0", d, 0);

        // AW and W together to word 1
        @(negedge clk);
        awaddr = 6'h04; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("same_bvalid", 32'(bvalid), 1);
        chk("same_bresp",  32'(bresp), 0);
        chk("same_word1",  cfg_out[63:32], 32'h1234_5678);
        chk("same_pulse",  32'(cfg_pulse), 32'h02);
        chk("same_awready_busy", 32'(awready), 0);
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("same_bvalid_done", 32'(bvalid), 0);
        chk("same_pulse_done",  32'(cfg_pulse), 0);
        chk("same_awready_back", 32'(awready), 1);
        chk("same_wready_back",  32'(wready), 1);
        rd(6'h1C, d, r);
        chk("rd_cnt1", d, 1);
        chk("pulse_one_cycle", pulse_cnt, 1);

        // W leads AW by three cycles, partial strobe, B stalled
        @(negedge clk);
        awaddr = 6'h00; wdata = 32'hAABB_CCDD; wstrb = 4'b0101;
        wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        chk("wfirst_wready_low", 32'(wready), 0);
        chk("wfirst_awready",    32'(awready), 1);
        chk("wfirst_no_b",       32'(bvalid), 0);
        repeat (2) @(negedge clk);
        awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        chk("wfirst_bvalid", 32'(bvalid), 1);
        chk("wfirst_word0",  cfg_out[31:0], 32'h00BB_00DD);
        chk("wfirst_pulse",  32'(cfg_pulse), 32'h01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_bvalid",  32'(bvalid), 1);
            chk("stall_bresp",   32'(bresp), 0);
            chk("stall_awready", 32'(awready), 0);
            chk("stall_wready",  32'(wready), 0);
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("stall_release", 32'(bvalid), 0);

        // Writes to read-only and unmapped offsets
        wr(6'h18, 32'hFFFF_FFFF, 4'hF, r);
        chk("wr_id_slverr", 32'(r), 2);
        wr(6'h24, 32'h1111_1111, 4'hF, r);
        chk("wr_unmapped_slverr", 32'(r), 2);
        chk("slverr_no_pulse", pulse_cnt, 2);
        rd(6'h1B, d, r);
        chk("rd_id_unchanged", d, 32'hB1AC_C057);
        rd(6'h1C, d, r);
        chk("rd_cnt2", d, 2);
        rd(6'h30, d, r);
        chk("rd_unmapped_data", d, 0);
        chk("rd_unmapped_resp", 32'(r), 2);

        // Zero strobe still commits and counts
        wr(6'h14, 32'hFFFF_FFFF, 4'h0, r);
        chk("strb0_resp", 32'(r), 0);
        chk("strb0_word5", cfg_out[191:160], 0);
        chk("strb0_pulse", pulse_cnt, 3);
        rd(6'h1C, d, r);
        chk("rd_cnt3", d, 3);

        // Read and write of word 1 on the same edge
        @(negedge clk);
        awaddr = 6'h04; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; araddr = 6'h04;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("coll_rvalid", 32'(rvalid), 1);
        chk("coll_old",    rdata, 32'h1234_5678);
        chk("coll_bvalid", 32'(bvalid), 1);
        chk("coll_word1",  cfg_out[63:32], 32'hDEAD_BEEF);
        bready = 1; rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;
        rd(6'h04, d, r);
        chk("coll_new", d, 32'hDEAD_BEEF);

        // Reset while B and R responses are pending
        @(negedge clk);
        awaddr = 6'h08; wdata = 32'h5555_AAAA; wstrb = 4'hF; araddr = 6'h08;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("pre_rst_bvalid", 32'(bvalid), 1);
        chk("pre_rst_rvalid", 32'(rvalid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_bvalid", 32'(bvalid), 0);
        chk("mid_rst_rvalid", 32'(rvalid), 0);
        chk("mid_rst_cfg",    32'(|cfg_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bready = 1; rready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_b", 32'(bvalid), 0);
            chk("post_rst_no_r", 32'(rvalid), 0);
        end
        bready = 0; rready = 0;
        rd(6'h1C, d, r);
        chk("post_rst_cnt", d, 0);
        rd(6'h04, d, r);
        chk("post_rst_word1", d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
